// File: rtl/commutation_ctrl.sv
// Six-step BLDC commutation sequencer: hall sync, coil-select table, slew-limited duty,
// run/brake/idle/fault modes with all drive changes aligned to PWM_synch.
module commutation_ctrl #(
    parameter logic [10:0] RAMP_STEP     = 11'd8,
    parameter logic [10:0] BRAKE_DUTY    = 11'd1024,
    parameter int unsigned FAULT_PERIODS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        brake_n,
    input  logic [10:0] target_duty,
    input  logic        PWM_synch,
    input  logic        hallGrn,
    input  logic        hallYlw,
    input  logic        hallBlu,
    output logic [1:0]  selGrn,
    output logic [1:0]  selYlw,
    output logic [1:0]  selBlu,
    output logic [10:0] duty,
    output logic        fault,
    output logic        running
);

    localparam int unsigned DW = 11;
    localparam int unsigned CW = 4;
    localparam logic [5:0]  SEL_OFF   = 6'b00_00_00;
    localparam logic [5:0]  SEL_BRAKE = 6'b01_01_01;

    typedef enum logic [1:0] {IDLE, RUN, BRAKE, FAULT} state_e;

    state_e          state_q, state_d;
    logic [2:0]      hall_s1_q, hall_s2_q;
    logic [2:0]      hall_reg_q, hall_reg_d;
    logic [5:0]      sel_q, sel_d;
    logic [DW-1:0]   duty_q, duty_d;
    logic            fault_q, fault_d;
    logic            running_q, running_d;
    logic [CW-1:0]   inv_cnt_q, inv_cnt_d;
    logic [CW-1:0]   inv_inc;
    logic            hall_valid;

    function automatic logic [5:0] commutate(input logic [2:0] h);
        case (h)
            3'b101:  return 6'b10_01_00;
            3'b100:  return 6'b10_00_01;
            3'b110:  return 6'b00_10_01;
            3'b010:  return 6'b01_10_00;
            3'b011:  return 6'b01_00_10;
            3'b001:  return 6'b00_01_10;
            default: return SEL_OFF;
        endcase
    endfunction

    // Rising duty steps by RAMP_STEP clamped at the target; falling duty snaps to target.
    function automatic logic [DW-1:0] ramp(input logic [DW-1:0] cur, input logic [DW-1:0] tgt);
        logic [DW:0] sum;
        sum = (DW+1)'(cur) + (DW+1)'(RAMP_STEP);
        if (cur >= tgt) return tgt;
        if (sum > (DW+1)'(tgt)) return tgt;
        return sum[DW-1:0];
    endfunction

    assign hall_reg_d = PWM_synch ? hall_s2_q : hall_reg_q;
    assign hall_valid = (hall_reg_d != 3'b000) && (hall_reg_d != 3'b111);
    assign inv_inc    = (inv_cnt_q == {CW{1'b1}}) ? inv_cnt_q : inv_cnt_q + CW'(1);

    // Next-state and next-output selection; en=0 bypasses the PWM_synch alignment.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        duty_d    = duty_q;
        fault_d   = fault_q;
        running_d = running_q;
        inv_cnt_d = inv_cnt_q;
        if (!en) begin
            state_d   = IDLE;
            sel_d     = SEL_OFF;
            duty_d    = '0;
            fault_d   = 1'b0;
            running_d = 1'b0;
            inv_cnt_d = '0;
        end else if (PWM_synch) begin
            unique case (state_q)
                IDLE, BRAKE: begin
                    if (brake_n) begin
                        state_d   = RUN;
                        sel_d     = commutate(hall_reg_d);
                        duty_d    = ramp('0, target_duty);
                        running_d = 1'b1;
                        inv_cnt_d = '0;
                    end else begin
                        state_d   = BRAKE;
                        sel_d     = SEL_BRAKE;
                        duty_d    = BRAKE_DUTY;
                        running_d = 1'b0;
                    end
                end
                RUN: begin
                    inv_cnt_d = hall_valid ? '0 : inv_inc;
                    if (!hall_valid && (32'(inv_inc) >= FAULT_PERIODS)) begin
                        state_d   = FAULT;
                        sel_d     = SEL_OFF;
                        duty_d    = '0;
                        fault_d   = 1'b1;
                        running_d = 1'b0;
                    end else if (!brake_n) begin
                        state_d   = BRAKE;
                        sel_d     = SEL_BRAKE;
                        duty_d    = BRAKE_DUTY;
                        running_d = 1'b0;
                        inv_cnt_d = '0;
                    end else if (!hall_valid) begin
                        sel_d = SEL_OFF;
                    end else begin
                        sel_d  = commutate(hall_reg_d);
                        duty_d = ramp(duty_q, target_duty);
                    end
                end
                FAULT: begin
                    sel_d   = SEL_OFF;
                    duty_d  = '0;
                    fault_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hall_s1_q  <= '0;
            hall_s2_q  <= '0;
            hall_reg_q <= '0;
            sel_q      <= SEL_OFF;
            duty_q     <= '0;
            fault_q    <= 1'b0;
            running_q  <= 1'b0;
            inv_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            hall_s1_q  <= {hallGrn, hallYlw, hallBlu};
            hall_s2_q  <= hall_s1_q;
            hall_reg_q <= hall_reg_d;
            sel_q      <= sel_d;
            duty_q     <= duty_d;
            fault_q    <= fault_d;
            running_q  <= running_d;
            inv_cnt_q  <= inv_cnt_d;
        end
    end

    assign selGrn  = sel_q[5:4];
    assign selYlw  = sel_q[3:2];
    assign selBlu  = sel_q[1:0];
    assign duty    = duty_q;
    assign fault   = fault_q;
    assign running = running_q;

endmodule

// File: tb/tb_commutation_ctrl.sv
// Directed scoreboard bench for commutation_ctrl: commutation table, ramp, brake, fault, priority.
module tb_commutation_ctrl;

    logic        clk = 1'b0;
    logic        rst, en, brake_n, PWM_synch;
    logic [10:0] target_duty;
    logic        hallGrn, hallYlw, hallBlu;
    logic [1:0]  selGrn, selYlw, selBlu;
    logic [10:0] duty;
    logic        fault, running;
    logic [18:0] obs;

    typedef struct {
        logic [18:0] v;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [10:0] m_duty;
    logic [2:0]  seq [6];

    commutation_ctrl dut (
        .clk(clk), .rst(rst), .en(en), .brake_n(brake_n), .target_duty(target_duty),
        .PWM_synch(PWM_synch), .hallGrn(hallGrn), .hallYlw(hallYlw), .hallBlu(hallBlu),
        .selGrn(selGrn), .selYlw(selYlw), .selBlu(selBlu), .duty(duty),
        .fault(fault), .running(running)
    );

    always #5 clk = ~clk;

    assign obs = {selGrn, selYlw, selBlu, duty, fault, running};

    function automatic logic [5:0] tbl(input logic [2:0] h);
        case (h)
            3'b101:  return 6'b10_01_00;
            3'b100:  return 6'b10_00_01;
            3'b110:  return 6'b00_10_01;
            3'b010:  return 6'b01_10_00;
            3'b011:  return 6'b01_00_10;
            3'b001:  return 6'b00_01_10;
            default: return 6'b00_00_00;
        endcase
    endfunction

    function automatic logic [10:0] ramp(input logic [10:0] cur, input logic [10:0] tgt);
        int s;
        s = int'(cur) + 8;
        if (cur >= tgt) return tgt;
        return (s > int'(tgt)) ? tgt : 11'(s);
    endfunction

    task automatic push(input string tag, input logic [5:0] sel, input logic [10:0] d,
                        input logic f, input logic r);
        exp_t e;
        e.v   = {sel, d, f, r};
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: observed %h, no expected entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.v) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_hall(input logic [2:0] h);
        {hallGrn, hallYlw, hallBlu} = h;
        tick(2);
    endtask

    task automatic now(input string tag, input logic [5:0] sel, input logic [10:0] d,
                       input logic f, input logic r);
        push(tag, sel, d, f, r);
        check();
    endtask

    // One PWM period: check one clk after the pulse, then again before the next pulse.
    task automatic step(input string tag, input logic [5:0] sel, input logic [10:0] d,
                        input logic f, input logic r);
        push(tag, sel, d, f, r);
        PWM_synch = 1'b1;
        tick(1);
        PWM_synch = 1'b0;
        check();
        tick(3);
        push({tag, "_hold"}, sel, d, f, r);
        check();
    endtask

    initial begin
        seq[0] = 3'b101; seq[1] = 3'b100; seq[2] = 3'b110;
        seq[3] = 3'b010; seq[4] = 3'b011; seq[5] = 3'b001;
        rst = 1'b1; en = 1'b0; brake_n = 1'b1; PWM_synch = 1'b0; target_duty = '0;
        {hallGrn, hallYlw, hallBlu} = 3'b000;

        for (int i = 0; i < 3; i++) begin
            en          = 1'($urandom_range(0, 1));
            brake_n     = 1'($urandom_range(0, 1));
            PWM_synch   = 1'($urandom_range(0, 1));
            target_duty = 11'($urandom_range(0, 2047));
            {hallGrn, hallYlw, hallBlu} = 3'($urandom_range(0, 7));
            tick(1);
        end
        now("reset", 6'b0, 11'd0, 1'b0, 1'b0);
        rst = 1'b0; en = 1'b0; PWM_synch = 1'b0;
        brake_n = 1'b1;
        step("idle_en0_a", 6'b0, 11'd0, 1'b0, 1'b0);
        brake_n = 1'b0;
        step("idle_en0_b", 6'b0, 11'd0, 1'b0, 1'b0);

        en = 1'b1; brake_n = 1'b1; target_duty = 11'd2047; m_duty = '0;
        for (int i = 0; i < 6; i++) begin
            set_hall(seq[i]);
            m_duty = ramp(m_duty, 11'd2047);
            step("comm_first", tbl(seq[i]), m_duty, 1'b0, 1'b1);
            m_duty = ramp(m_duty, 11'd2047);
            step("comm_second", tbl(seq[i]), m_duty, 1'b0, 1'b1);
        end

        en = 1'b0;
        tick(1);
        now("en_off", 6'b0, 11'd0, 1'b0, 1'b0);
        target_duty = 11'd100; m_duty = '0; en = 1'b1;
        for (int i = 0; i < 14; i++) begin
            m_duty = ramp(m_duty, 11'd100);
            step("ramp_up", tbl(3'b001), m_duty, 1'b0, 1'b1);
        end
        target_duty = 11'd40;
        step("ramp_down", tbl(3'b001), 11'd40, 1'b0, 1'b1);

        brake_n = 1'b0;
        step("brake", 6'b01_01_01, 11'd1024, 1'b0, 1'b0);
        step("brake_stay", 6'b01_01_01, 11'd1024, 1'b0, 1'b0);
        brake_n = 1'b1;
        step("brake_exit", tbl(3'b001), 11'd8, 1'b0, 1'b1);

        set_hall(3'b111);
        for (int i = 0; i < 3; i++) step("invalid_hz", 6'b0, 11'd8, 1'b0, 1'b1);
        step("fault_enter", 6'b0, 11'd0, 1'b1, 1'b0);
        en = 1'b0;
        tick(1);
        now("fault_clear", 6'b0, 11'd0, 1'b0, 1'b0);
        set_hall(3'b100);
        en = 1'b1;
        step("reentry", tbl(3'b100), 11'd8, 1'b0, 1'b1);
        set_hall(3'b111);
        for (int i = 0; i < 3; i++) step("invalid3", 6'b0, 11'd8, 1'b0, 1'b1);
        set_hall(3'b001);
        step("valid_after3", tbl(3'b001), 11'd16, 1'b0, 1'b1);
        set_hall(3'b111);
        step("inv_restart", 6'b0, 11'd16, 1'b0, 1'b1);

        set_hall(3'b110);
        target_duty = 11'd500; m_duty = 11'd16;
        for (int i = 0; i < 80 && m_duty != 11'd500; i++) begin
            m_duty = ramp(m_duty, 11'd500);
            step("ramp500", tbl(3'b110), m_duty, 1'b0, 1'b1);
        end
        tick(1);
        en = 1'b0;
        tick(1);
        now("en_drop_mid", 6'b0, 11'd0, 1'b0, 1'b0);

        target_duty = 11'd0; en = 1'b1; brake_n = 1'b1;
        step("run_target0", tbl(3'b110), 11'd0, 1'b0, 1'b1);
        brake_n = 1'b0; rst = 1'b1; PWM_synch = 1'b1;
        tick(1);
        now("rst_with_brake", 6'b0, 11'd0, 1'b0, 1'b0);
        rst = 1'b0; PWM_synch = 1'b0;
        tick(3);
        step("post_rst_brake", 6'b01_01_01, 11'd1024, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
